// File: rtl/dual_stepper_driver_pkg.sv
// -----------------------------------------------------------------------------
// Stepper_p
// Shared definitions for the dual-axis stepper pulse generator:
//   - StepperState_t : controller states (IDLE, SETUP, RUN, DONE)
//   - default step period and step pulse width, in clock cycles
// -----------------------------------------------------------------------------
package Stepper_p;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } StepperState_t;

  localparam int DEFAULT_PERIOD_CYCLES = 50000;
  localparam int DEFAULT_PULSE_CYCLES  = 500;

endpackage : Stepper_p

// File: rtl/dual_stepper_driver_axis.sv
// -----------------------------------------------------------------------------
// stepper_axis
// One motor axis. It latches the magnitude and direction of a signed step count
// and counts remaining steps down once per step period. It also drives a
// registered step pulse.
//
// Ports:
//   clk             : system clock
//   reset           : synchronous, active-low reset
//   i_load          : latch i_value (magnitude and direction)
//   i_value         : signed two's-complement step count
//   i_tick_last     : last tick of a RUN period; decrements a nonzero count
//   i_tick_in_pulse : next cycle is in RUN and inside the pulse window
//   o_step          : registered step pulse
//   o_dir           : registered direction, 1 = positive, 0 = negative or zero
//   o_le_one        : remaining count is 0 or 1
//   o_nonzero       : remaining count is nonzero
// -----------------------------------------------------------------------------
module stepper_axis #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_tick_last,
  input  logic             i_tick_in_pulse,
  output logic             o_step,
  output logic             o_dir,
  output logic             o_le_one,
  output logic             o_nonzero
);

  logic [WIDTH-1:0] r_remaining;
  logic [WIDTH-1:0] w_remaining_next;
  logic [WIDTH-1:0] w_magnitude;
  logic             r_step;
  logic             r_dir;

  // Negating in the same width makes the most negative value wrap to itself.
  // Read as unsigned, that value is exactly 2^(WIDTH-1), so no extra bit is needed.
  assign w_magnitude = i_value[WIDTH-1] ? (~i_value + WIDTH'(1)) : i_value;

  // NOTE: every signal driven here gets a default on the first line.
  // Without it, a path that leaves a signal unassigned infers a latch.
  always_comb begin
    w_remaining_next = r_remaining;
    if (i_load) begin
      w_remaining_next = w_magnitude;
    end else if (i_tick_last && (r_remaining != '0)) begin
      w_remaining_next = r_remaining - WIDTH'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments.
  // Every flop then samples pre-edge values, whatever the process order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_remaining <= '0;
      r_step      <= 1'b0;
      r_dir       <= 1'b0;
    end else begin
      r_remaining <= w_remaining_next;
      // The pulse is computed from next-cycle values so that the pin is a flop
      // and still rises in the first RUN cycle of a step.
      r_step      <= i_tick_in_pulse && (w_remaining_next != '0);
      if (i_load) begin
        r_dir <= !i_value[WIDTH-1] && (i_value != '0);
      end
    end
  end

  assign o_step    = r_step;
  assign o_dir     = r_dir;
  assign o_le_one  = (r_remaining <= WIDTH'(1));
  assign o_nonzero = (r_remaining != '0);

endmodule : stepper_axis

// File: rtl/dual_stepper_driver.sv
// -----------------------------------------------------------------------------
// dual_stepper_driver
// Two-axis stepper pulse generator. On a trigger in IDLE it latches signed X/Y
// step counts. It waits one period of direction setup, then steps both axes
// together at one step per period. It ends with a single-cycle done pulse.
//
// Ports:
//   clk         : system clock
//   reset       : synchronous, active-low reset
//   trigger     : start request, sampled only in IDLE
//   num_steps_x : signed X step count (STEPPER_X_BITS)
//   num_steps_y : signed Y step count (STEPPER_Y_BITS)
//   step_x/y    : step pulses, high for PULSE_CYCLES at the start of each period
//   dir_x/y     : 1 = positive, 0 = negative or zero; held until the next trigger
//   busy        : high in SETUP, RUN and DONE
//   done        : single-cycle completion pulse
// All outputs are registered.
// -----------------------------------------------------------------------------
`ifndef STEPPER_X_BITS
  `define STEPPER_X_BITS 16
`endif
`ifndef STEPPER_Y_BITS
  `define STEPPER_Y_BITS 16
`endif

module dual_stepper_driver
  import Stepper_p::*;
#(
  parameter int STEPPER_X_BITS = `STEPPER_X_BITS,
  parameter int STEPPER_Y_BITS = `STEPPER_Y_BITS,
  parameter int PERIOD_CYCLES  = DEFAULT_PERIOD_CYCLES,
  parameter int PULSE_CYCLES   = DEFAULT_PULSE_CYCLES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      trigger,
  input  logic [STEPPER_X_BITS-1:0] num_steps_x,
  input  logic [STEPPER_Y_BITS-1:0] num_steps_y,
  output logic                      step_x,
  output logic                      step_y,
  output logic                      dir_x,
  output logic                      dir_y,
  output logic                      busy,
  output logic                      done
);

  localparam int TICK_W = $clog2(PERIOD_CYCLES);

  StepperState_t     r_state;
  StepperState_t     w_state_next;
  logic [TICK_W-1:0] r_tick;
  logic [TICK_W-1:0] w_tick_next;
  logic              w_tick_last;
  logic              w_load;
  logic              w_run_last;
  logic              w_in_pulse;
  logic              r_busy;
  logic              r_done;
  logic              w_le_one_x;
  logic              w_le_one_y;
  logic              w_nonzero_x;
  logic              w_nonzero_y;

  assign w_tick_last = (r_tick == TICK_W'(PERIOD_CYCLES - 1));
  assign w_run_last  = (r_state == RUN) && w_tick_last;
  assign w_in_pulse  = (w_state_next == RUN) && (w_tick_next < TICK_W'(PULSE_CYCLES));

  // Next-state and tick logic. The tick restarts at 0 on every state change.
  always_comb begin
    w_state_next = r_state;
    w_tick_next  = r_tick;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        w_tick_next = '0;
        if (trigger) begin
          w_state_next = SETUP;
          w_load       = 1'b1;
        end
      end
      SETUP: begin
        if (w_tick_last) begin
          w_tick_next  = '0;
          w_state_next = (w_nonzero_x || w_nonzero_y) ? RUN : DONE;
        end else begin
          w_tick_next = r_tick + TICK_W'(1);
        end
      end
      RUN: begin
        if (w_tick_last) begin
          w_tick_next = '0;
          // The counts seen here are the pre-decrement values.
          // When both are at most 1, this period was the final step.
          if (w_le_one_x && w_le_one_y) begin
            w_state_next = DONE;
          end
        end else begin
          w_tick_next = r_tick + TICK_W'(1);
        end
      end
      DONE: begin
        w_tick_next  = '0;
        w_state_next = IDLE;
      end
      default: begin
        w_tick_next  = '0;
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_tick  <= w_tick_next;
      r_busy  <= (w_state_next != IDLE);
      r_done  <= (w_state_next == DONE);
    end
  end

  stepper_axis #(
    .WIDTH (STEPPER_X_BITS)
  ) u_axis_x (
    .clk             (clk),
    .reset           (reset),
    .i_load          (w_load),
    .i_value         (num_steps_x),
    .i_tick_last     (w_run_last),
    .i_tick_in_pulse (w_in_pulse),
    .o_step          (step_x),
    .o_dir           (dir_x),
    .o_le_one        (w_le_one_x),
    .o_nonzero       (w_nonzero_x)
  );

  stepper_axis #(
    .WIDTH (STEPPER_Y_BITS)
  ) u_axis_y (
    .clk             (clk),
    .reset           (reset),
    .i_load          (w_load),
    .i_value         (num_steps_y),
    .i_tick_last     (w_run_last),
    .i_tick_in_pulse (w_in_pulse),
    .o_step          (step_y),
    .o_dir           (dir_y),
    .o_le_one        (w_le_one_y),
    .o_nonzero       (w_nonzero_y)
  );

  assign busy = r_busy;
  assign done = r_done;

endmodule : dual_stepper_driver

// File: tb/tb_dual_stepper_driver.sv
// -----------------------------------------------------------------------------
// tb_dual_stepper_driver
// Bench for dual_stepper_driver with PERIOD_CYCLES=4, PULSE_CYCLES=2 and 4-bit
// counts. A posedge model decides when a trigger is accepted and pushes the
// expected done edge to a scoreboard queue. A negedge monitor compares every
// output against the timing formulas. It pops the queue on each done and checks
// pulse counts.
// -----------------------------------------------------------------------------
module tb_dual_stepper_driver;

  localparam int P  = 4;
  localparam int PW = 2;
  localparam int W  = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                trigger;
  logic signed [W-1:0] num_steps_x;
  logic signed [W-1:0] num_steps_y;
  logic                step_x, step_y, dir_x, dir_y, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  dual_stepper_driver #(
    .STEPPER_X_BITS (W),
    .STEPPER_Y_BITS (W),
    .PERIOD_CYCLES  (P),
    .PULSE_CYCLES   (PW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .trigger     (trigger),
    .num_steps_x (num_steps_x),
    .num_steps_y (num_steps_y),
    .step_x      (step_x),
    .step_y      (step_y),
    .dir_x       (dir_x),
    .dir_y       (dir_y),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  // Reference model state, updated at each rising edge
  int   e = 0;            // rising edges seen so far
  bit   have_move = 0;
  int   m_k, m_ax, m_ay, m_n;
  logic m_dx = 1'b0, m_dy = 1'b0;
  int   cnt_x, cnt_y;
  logic prev_x = 1'b0, prev_y = 1'b0;
  int   sb_q[$];          // expected done edges

  always @(posedge clk) begin
    int xi, yi;
    e = e + 1;
    if (!reset) begin
      have_move = 0;
      m_dx = 1'b0;
      m_dy = 1'b0;
      sb_q.delete();
    end else if (trigger && (!have_move || e >= m_k + P * (1 + m_n) + 2)) begin
      xi   = int'(num_steps_x);
      yi   = int'(num_steps_y);
      m_ax = (xi < 0) ? -xi : xi;
      m_ay = (yi < 0) ? -yi : yi;
      m_n  = (m_ax > m_ay) ? m_ax : m_ay;
      m_dx = (xi > 0);
      m_dy = (yi > 0);
      m_k  = e;
      have_move = 1;
      cnt_x = 0;
      cnt_y = 0;
      sb_q.push_back(e + P * (1 + m_n));
    end
  end

  // Monitor: compares every output once per cycle, away from the active edge
  always @(negedge clk) begin
    logic [5:0] expv;
    logic       eb, ed, esx, esy;
    int         d, i, ph;
    if (e > 0) begin
      eb = 1'b0; ed = 1'b0; esx = 1'b0; esy = 1'b0;
      if (have_move) begin
        d = e - m_k;
        if (d >= 0 && d <= P * (1 + m_n)) begin
          eb = 1'b1;
          ed = (d == P * (1 + m_n));
          if (d >= P && d < P * (1 + m_n)) begin
            i   = (d - P) / P;
            ph  = (d - P) % P;
            esx = (i < m_ax) && (ph < PW);
            esy = (i < m_ay) && (ph < PW);
          end
        end
      end
      expv = {eb, ed, esx, esy, m_dx, m_dy};
      check("outs{busy,done,sx,sy,dx,dy}", {26'd0, busy, done, step_x, step_y, dir_x, dir_y},
            {26'd0, expv});
      if (step_x === 1'b1 && prev_x !== 1'b1) cnt_x++;
      if (step_y === 1'b1 && prev_y !== 1'b1) cnt_y++;
      prev_x = step_x;
      prev_y = step_y;
      if (done === 1'b1) begin
        check("done_expected", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          check("done_edge", 32'(e), 32'(sb_q.pop_front()));
          check("pulses_x", 32'(cnt_x), 32'(m_ax));
          check("pulses_y", 32'(cnt_y), 32'(m_ay));
        end
      end
    end
  end

  task automatic run_move(input int x, input int y);
    int ax, ay, n;
    ax = (x < 0) ? -x : x;
    ay = (y < 0) ? -y : y;
    n  = (ax > ay) ? ax : ay;
    @(negedge clk);
    num_steps_x = W'(x);
    num_steps_y = W'(y);
    trigger     = 1'b1;
    @(negedge clk);
    trigger     = 1'b0;
    num_steps_x = W'($urandom);
    num_steps_y = W'($urandom);
    repeat (P * (2 + n) + 2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    trigger     = 1'b0;
    num_steps_x = '0;
    num_steps_y = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_move(3, -2);
    run_move(0, 0);
    run_move(-8, 7);

    // Trigger held high across a 2-step move with inputs changing mid-move.
    // The second acceptance must wait for the IDLE cycle after done.
    @(negedge clk);
    num_steps_x = 4'sd2;
    num_steps_y = 4'sd1;
    trigger     = 1'b1;
    repeat (5) @(negedge clk);
    num_steps_x = -4'sd3;
    num_steps_y = 4'sd5;
    repeat (11) @(negedge clk);
    trigger = 1'b0;
    repeat (30) @(negedge clk);

    // Reset pulse during an x=5 move: abort, no done, then a clean 1-step move
    @(negedge clk);
    num_steps_x = 4'sd5;
    num_steps_y = 4'sd0;
    trigger     = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    run_move(1, 0);

    for (int r = 0; r < 4; r++) begin
      run_move(int'($urandom_range(15)) - 8, int'($urandom_range(15)) - 8);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_dual_stepper_driver

// File: doc/dual_stepper_driver.md
# dual_stepper_driver

Two-axis stepper pulse generator directly downstream of the processor selector. It latches signed X/Y step counts and a trigger, drives step/direction pins for both motors concurrently at a fixed step rate, and returns a single-cycle done pulse. The selector routes that pulse back to the active linear or circular handler.

## Interface
- STEPPER_X_BITS, default `STEPPER_X_BITS: width of signed X step count.
- STEPPER_Y_BITS, default `STEPPER_Y_BITS: width of signed Y step count.
- PERIOD_CYCLES, default 50000: clock cycles per step period. Legal range ≥ 2.
- PULSE_CYCLES, default 500: step pulse high width in cycles. Legal range 1..PERIOD_CYCLES-1.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: one clock; reset is synchronous and active-low.
- trigger, in, 1: start request, sampled only in IDLE.
- num_steps_x, in, STEPPER_X_BITS: signed two's-complement X steps.
- num_steps_y, in, STEPPER_Y_BITS: signed two's-complement Y steps.
- step_x / step_y, out, 1: step pulses.
- dir_x / dir_y, out, 1: 1 = positive direction, 0 = negative or zero count.
- busy, out, 1: high in SETUP, RUN and DONE.
- done, out, 1: single-cycle completion pulse.

## Operation
- States:
  - IDLE: on trigger=1, latch the magnitudes and signs, then go to SETUP. Otherwise stay in IDLE.
  - SETUP: lasts exactly one period (direction setup time). At the end of the period, go to RUN if either magnitude is nonzero, otherwise go to DONE.
  - RUN: lasts one period per step.
  - DONE: lasts one cycle, with done=1. Always returns to IDLE.
- Magnitude latching: magnitude = |value| stored unsigned in the same width. The most negative value (-2^(N-1)) maps to 2^(N-1) with no overflow.
- Direction latching: dir = value > 0.
- The tick counter runs 0..PERIOD_CYCLES-1 in SETUP and RUN, and resets to 0 on entry to each state.
- RUN behaviour:
  - An axis with remaining > 0 drives step high while tick < PULSE_CYCLES.
  - At tick = PERIOD_CYCLES-1, each nonzero remaining count decrements.
  - RUN exits to DONE at tick = PERIOD_CYCLES-1 when both remaining counts are ≤ 1.
- The axes step simultaneously. The shorter axis finishes early and its step pin stays low afterwards.
- Triggers in SETUP, RUN or DONE are ignored and not queued. Inputs are not re-sampled.
- dir_x and dir_y hold their latched values until the next accepted trigger.
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-operation aborts immediately. No done pulse is issued, and pulses in progress are truncated.

## Timing
- Trigger accepted at edge k: busy=1 and dir valid from cycle k+1.
- First step pulse rises at cycle k+1+PERIOD_CYCLES.
- Step i (0-based) covers cycles k+1+PERIOD_CYCLES·(1+i) through that value plus PULSE_CYCLES-1.
- With n = max(|x|, |y|), done=1 at cycle k+1+PERIOD_CYCLES·(1+n). busy falls the cycle after.
- With n=0, done occurs at k+1+PERIOD_CYCLES with no pulses.
- Earliest next trigger acceptance: the cycle after done.
- All outputs are registered, with no combinational input-to-output paths.

## Structure
- Package Stepper_p holds:
  - the StepperState_t enum (IDLE, SETUP, RUN, DONE);
  - default PERIOD_CYCLES and PULSE_CYCLES constants.
- The top module holds the FSM and the shared tick counter.
- Sub-module stepper_axis, instantiated twice, handles one axis:
  - inputs: load, value, tick_last, tick_in_pulse;
  - holds the magnitude/direction latch and remaining-count register;
  - outputs: step, dir, and remaining ≤ 1.
  - Parameterized by width.

## Test plan
All tests use PERIOD_CYCLES=4, PULSE_CYCLES=2, 4-bit widths.
- x=3, y=-2, trigger at k:
  - dir_x=1 and dir_y=0 from k+1.
  - step_x high on k+5..6, k+9..10 and k+13..14.
  - step_y high on k+5..6 and k+9..10.
  - done=1 only at k+17.
- x=0, y=0: no step pulses, dir_x=dir_y=0, done at k+5, busy high on k+1..k+5.
- x=-8, y=7:
  - 8 step_x pulses with dir_x=0, and 7 step_y pulses with dir_y=1.
  - done at k+37 (checks the most-negative magnitude).
- Extra triggers: trigger held high throughout a 2-step move, with inputs changing mid-move.
  - Exactly 2 pulses per the originally latched values.
  - The next move starts only from the IDLE cycle after done.
- Reset low at k+7 during x=5: the next cycle has all outputs 0 and busy=0, and no done follows. A new x=1 move afterwards completes normally with done at trigger+9.
